fmps_packet_collector: RTL
==========================

Name: fmps_packet_collector

Overview:
Downstream consumer of the merged FMPS AXI stream leaving the axisMux, in the sysClk domain. Parses each packet (one header word, then NUM_DATA_WORDS data words) and validates header magic, length and index uniqueness per FA cycle. Stores accepted payloads in an index-addressed buffer for readback, and keeps per-cycle received bitmap, packet count and error statistics.

Parameters:
DATA_WIDTH, 32, AXIS tdata width
MAGIC_WIDTH, 16, header magic field width
MAGIC_START_BIT, 16, LSB of magic in header
INDEX_WIDTH, 5, packet index field width; buffer depth = 2**INDEX_WIDTH
INDEX_START_BIT, 10, LSB of index in header
NUM_DATA_WORDS, 1, payload words per packet (>=1)
ERR_CNT_WIDTH, 16, width of saturating error counter

Ports:
sysClk  in  1  clock
sysReset_n  in  1  synchronous active-low reset
newCycleStrobe  in  1  FA cycle boundary pulse (already in sysClk domain)
expectedHeaderMagic  in  MAGIC_WIDTH  magic compared against each header
s_tvalid  in  1  AXIS valid
s_tready  out  1  AXIS ready
s_tlast  in  1  AXIS last
s_tdata  in  DATA_WIDTH  AXIS data
packetStrobe  out  1  one-cycle pulse per accepted packet
packetIndex  out  INDEX_WIDTH  index of accepted packet
packetData  out  DATA_WIDTH*NUM_DATA_WORDS  payload, word 0 in LSBs
statusStrobe  out  1  one-cycle pulse per completed packet (good or bad)
statusCode  out  2  0 OK, 1 bad magic, 2 bad length, 3 duplicate index
receivedBitmap  out  2**INDEX_WIDTH  indices accepted this cycle
packetsLastCycle  out  INDEX_WIDTH+1  accepted count latched at newCycleStrobe
errorCount  out  ERR_CNT_WIDTH  saturating count of non-OK statuses
readAddress  in  INDEX_WIDTH  buffer read address
readData  out  DATA_WIDTH*NUM_DATA_WORDS  buffer data, 1-cycle latency

Behaviour:
- Reset (sysReset_n=0 at posedge): s_tready=0, all strobes 0, statusCode=0, packetIndex=0, packetData=0, bitmap=0, packetsLastCycle=0, errorCount=0, FSM=S_HEADER, internal per-cycle count=0. Buffer contents undefined. s_tready=1 from the first cycle after reset is released; never deasserted otherwise.
- Beat = s_tvalid & s_tready.
- FSM S_HEADER: on beat latch index and magic-ok flag, clear word counter. If tlast on the header: complete with code 1 if magic bad, else 2. Otherwise go to S_DATA.
- S_DATA: shift word into payload register at position = word counter. tlast before word NUM_DATA_WORDS-1: complete with code 2 (bad magic takes priority, code 1). tlast on word NUM_DATA_WORDS-1: complete (code 1 if magic bad, 3 if bitmap[index] already set, else 0). Word NUM_DATA_WORDS-1 without tlast: go to S_DRAIN.
- S_DRAIN: discard beats until tlast; then complete with code 1 if magic bad else 2.
- Completion: statusStrobe and statusCode registered 1 cycle after the final beat. Code 0 additionally pulses packetStrobe in the same cycle with packetIndex/packetData valid, writes the buffer, sets bitmap[index] and increments the per-cycle count. Codes 1-3 increment errorCount (saturates at all-ones); codes 1-3 never write the buffer or bitmap. FSM returns to S_HEADER.
- Back-to-back packets with no idle beats: sustained at full rate.
- newCycleStrobe: packetsLastCycle <= per-cycle count; bitmap and count cleared. If it coincides with an OK completion, the clear is applied first and the completing packet is recorded in the new cycle (bitmap bit set, count=1). A packet in progress is not aborted; it is attributed to the new cycle.
- Duplicate check uses the bitmap value after any same-cycle clear.
- Buffer read: readData registered from readAddress, 1-cycle latency; a same-cycle write to the same address returns the old data.
- Reset mid-packet: partial packet is dropped and no status is emitted; the next beat after reset is treated as a header.

Decomposition:
- Package fmps_pkg: status code constants (OK/BAD_MAGIC/BAD_LENGTH/DUPLICATE), default header field positions and widths, default magic 16'hB6CF, FSM state encoding.
- Sub-module fmps_packet_buffer: simple dual-port RAM, one sync write port and one registered read port, depth 2**INDEX_WIDTH.

Test Plan:
- Send header 0xB6CF_0C00 (index 3) + data 0x03CACA01, tlast on data -> 1 cycle later packetStrobe=1, packetIndex=3, packetData=0x03CACA01, statusCode=0, bitmap=0x8; readAddress=3 -> readData=0x03CACA01 the next cycle.
- Send header with magic 0x1234 -> statusCode=1, no packetStrobe, bitmap unchanged, errorCount=1.
- Send a header with tlast on it -> code 2; send header+2 data words (NUM_DATA_WORDS=1) -> code 2 at the second word's tlast; the next valid packet is accepted.
- Send index 5 twice in one cycle -> first code 0, second code 3, buffer keeps the first payload; after newCycleStrobe, index 5 is accepted again.
- Send 16 distinct indices, then pulse newCycleStrobe -> packetsLastCycle=16, bitmap=0; newCycleStrobe coincident with a completion -> bitmap has only that bit, next latch counts it.
- Run 4 back-to-back packets with tvalid held high, then assert reset mid-packet -> all 4 strobes 1 cycle after each tlast; after reset, outputs are at reset values and the partial packet is not reported.

Source files
------------

// File: rtl/fmps_pkg.sv
// Shared definitions for the FMPS packet collector: status codes, default header
// layout and magic, and the packet parser FSM states.
package fmps_pkg;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_BAD_MAGIC  = 2'd1,
    ST_BAD_LENGTH = 2'd2,
    ST_DUPLICATE  = 2'd3
  } fmps_status_e;

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DRAIN  = 2'd2
  } fmps_state_e;

  localparam int              FMPS_DATA_WIDTH      = 32;
  localparam int              FMPS_MAGIC_WIDTH     = 16;
  localparam int              FMPS_MAGIC_START_BIT = 16;
  localparam int              FMPS_INDEX_WIDTH     = 5;
  localparam int              FMPS_INDEX_START_BIT = 10;
  localparam logic [15:0]     FMPS_DEFAULT_MAGIC   = 16'hB6CF;

endpackage

// File: rtl/fmps_packet_buffer.sv
// Index-addressed payload store: one synchronous write port and one registered
// read port; a same-cycle write to the read address returns the old word.
module fmps_packet_buffer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmps_packet_collector.sv
// Parses the merged FMPS AXI stream into header + payload packets, validates them,
// stores accepted payloads by index and tracks per-FA-cycle reception statistics.
module fmps_packet_collector
  import fmps_pkg::*;
#(
  parameter int DATA_WIDTH      = FMPS_DATA_WIDTH,
  parameter int MAGIC_WIDTH     = FMPS_MAGIC_WIDTH,
  parameter int MAGIC_START_BIT = FMPS_MAGIC_START_BIT,
  parameter int INDEX_WIDTH     = FMPS_INDEX_WIDTH,
  parameter int INDEX_START_BIT = FMPS_INDEX_START_BIT,
  parameter int NUM_DATA_WORDS  = 1,
  parameter int ERR_CNT_WIDTH   = 16
) (
  input  logic                                 sysClk,
  input  logic                                 sysReset_n,
  input  logic                                 newCycleStrobe,
  input  logic [MAGIC_WIDTH-1:0]               expectedHeaderMagic,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic                                 s_tlast,
  input  logic [DATA_WIDTH-1:0]                s_tdata,
  output logic                                 packetStrobe,
  output logic [INDEX_WIDTH-1:0]               packetIndex,
  output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] packetData,
  output logic                                 statusStrobe,
  output logic [1:0]                           statusCode,
  output logic [2**INDEX_WIDTH-1:0]            receivedBitmap,
  output logic [INDEX_WIDTH:0]                 packetsLastCycle,
  output logic [ERR_CNT_WIDTH-1:0]             errorCount,
  input  logic [INDEX_WIDTH-1:0]               readAddress,
  output logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] readData
);

  localparam int BITMAP_W  = 2**INDEX_WIDTH;
  localparam int PAYLOAD_W = DATA_WIDTH*NUM_DATA_WORDS;
  localparam int WC_W      = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_DATA_WORDS-1);

  fmps_state_e            state_q, state_nxt;
  logic                   tready_q;
  logic                   beat_p0;
  logic                   hdr_magic_ok_p0;
  logic [INDEX_WIDTH-1:0] hdr_index_p0;
  logic [INDEX_WIDTH-1:0] index_q;
  logic                   magic_ok_q;
  logic [WC_W-1:0]        word_cnt_q;
  logic [PAYLOAD_W-1:0]   payload_q, payload_nxt;
  logic                   cmpl_vld_p0;
  logic                   cmpl_ok_p0;
  fmps_status_e           cmpl_code_p0;
  logic [BITMAP_W-1:0]    bitmap_q, bitmap_eff_p0, index_onehot_p0;
  logic [INDEX_WIDTH:0]   cycle_cnt_q, cycle_cnt_eff_p0;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s_tready        = tready_q;
  assign receivedBitmap  = bitmap_q;
  assign beat_p0         = s_tvalid & tready_q;
  assign hdr_magic_ok_p0 = (s_tdata[MAGIC_START_BIT +: MAGIC_WIDTH] == expectedHeaderMagic);
  assign hdr_index_p0    = s_tdata[INDEX_START_BIT +: INDEX_WIDTH];

  // A cycle boundary sampled on the completing edge clears first, so the duplicate
  // check and the bitmap/count update both see the new, empty cycle.
  assign bitmap_eff_p0    = newCycleStrobe ? '0 : bitmap_q;
  assign cycle_cnt_eff_p0 = newCycleStrobe ? '0 : cycle_cnt_q;
  assign index_onehot_p0  = {{(BITMAP_W-1){1'b0}}, 1'b1} << index_q;
  assign cmpl_ok_p0       = cmpl_vld_p0 && (cmpl_code_p0 == ST_OK);

  always_comb begin
    state_nxt    = state_q;
    cmpl_vld_p0  = 1'b0;
    cmpl_code_p0 = ST_OK;
    payload_nxt  = payload_q;
    if (beat_p0) begin
      unique case (state_q)
        S_HEADER: begin
          if (s_tlast) begin
            cmpl_vld_p0 = 1'b1;
            if (hdr_magic_ok_p0) cmpl_code_p0 = ST_BAD_LENGTH;
            else                 cmpl_code_p0 = ST_BAD_MAGIC;
          end else begin
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          for (int w = 0; w < NUM_DATA_WORDS; w++) begin
            if (word_cnt_q == WC_W'(w)) payload_nxt[w*DATA_WIDTH +: DATA_WIDTH] = s_tdata;
          end
          if (s_tlast) begin
            cmpl_vld_p0 = 1'b1;
            state_nxt   = S_HEADER;
            if (!magic_ok_q)                 cmpl_code_p0 = ST_BAD_MAGIC;
            else if (word_cnt_q != LAST_WORD) cmpl_code_p0 = ST_BAD_LENGTH;
            else if (bitmap_eff_p0[index_q])  cmpl_code_p0 = ST_DUPLICATE;
            else                              cmpl_code_p0 = ST_OK;
          end else if (word_cnt_q == LAST_WORD) begin
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (s_tlast) begin
            cmpl_vld_p0 = 1'b1;
            state_nxt   = S_HEADER;
            if (magic_ok_q) cmpl_code_p0 = ST_BAD_LENGTH;
            else            cmpl_code_p0 = ST_BAD_MAGIC;
          end
        end
        default: state_nxt = S_HEADER;
      endcase
    end
  end

  // Parse stage -> completion stage: control and outputs registered on the final beat
  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      state_q          <= S_HEADER;
      tready_q         <= 1'b0;
      statusStrobe     <= 1'b0;
      statusCode       <= 2'd0;
      packetStrobe     <= 1'b0;
      packetIndex      <= '0;
      packetData       <= '0;
      bitmap_q         <= '0;
      cycle_cnt_q      <= '0;
      packetsLastCycle <= '0;
      errorCount       <= '0;
    end else begin
      state_q      <= state_nxt;
      tready_q     <= 1'b1;
      statusStrobe <= cmpl_vld_p0;
      packetStrobe <= cmpl_ok_p0;
      if (cmpl_vld_p0) statusCode <= cmpl_code_p0;
      if (cmpl_ok_p0) begin
        packetIndex <= index_q;
        packetData  <= payload_nxt;
      end
      if (newCycleStrobe) packetsLastCycle <= cycle_cnt_q;
      bitmap_q    <= bitmap_eff_p0 | (cmpl_ok_p0 ? index_onehot_p0 : '0);
      cycle_cnt_q <= cycle_cnt_eff_p0 + {{INDEX_WIDTH{1'b0}}, cmpl_ok_p0};
      if (cmpl_vld_p0 && !cmpl_ok_p0) errorCount <= sat_inc(errorCount);
    end
  end

  always_ff @(posedge sysClk) begin
    payload_q <= payload_nxt;
    if (beat_p0) begin
      if (state_q == S_HEADER) begin
        index_q    <= hdr_index_p0;
        magic_ok_q <= hdr_magic_ok_p0;
        word_cnt_q <= '0;
      end else if (state_q == S_DATA) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  fmps_packet_buffer #(
    .ADDR_W (INDEX_WIDTH),
    .DATA_W (PAYLOAD_W)
  ) u_buffer (
    .clk     (sysClk),
    .wr_en   (cmpl_ok_p0 & sysReset_n),
    .wr_addr (index_q),
    .wr_data (payload_nxt),
    .rd_addr (readAddress),
    .rd_data (readData)
  );

endmodule
